ctrlseq: RTL and testbench

CTRLSEQ -- requirements
Module: ctrlseq

---
 rtl/sync_pkg.sv | 25 ++
 rtl/ctrlseq_cfgmux.sv | 76 +++++++
 rtl/ctrlseq.sv | 186 ++++++++++++++++++
 tb/tb_ctrlseq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the measurement sequencer: FSM encoding, default
// parameter values and the host address map.
package sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_DW   = 16;
  localparam int DEF_NSLV = 4;
  localparam int DEF_SAW  = 2;
  localparam int DEF_RW   = 8;
  localparam int DEF_TW   = 16;

  // Host address is {slave index, register index}; register field starts at bit 0.
  localparam int REG_LSB = 0;

  function automatic int addr_w(input int nslv, input int saw);
    return $clog2(nslv) + saw;
  endfunction

endpackage

// File: rtl/ctrlseq_cfgmux.sv
// Host access path: slave address decode, write steering and registered read mux.
// Expects NSLV >= 2 so the slave-index field is at least one bit wide.
module ctrlseq_cfgmux
  import sync_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NSLV = DEF_NSLV,
  parameter int SAW  = DEF_SAW,
  localparam int IW  = $clog2(NSLV),
  localparam int AW  = addr_w(NSLV, SAW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_w_i,
  input  logic               cfg_r_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [DW-1:0]      cfg_wdata_i,
  input  logic               idle_i,
  input  logic [NSLV*DW-1:0] slv_rdata_i,
  output logic [DW-1:0]      cfg_rdata_o,
  output logic               cfg_rvalid_o,
  output logic               cfg_err_o,
  output logic [NSLV-1:0]    slv_we_o,
  output logic [SAW-1:0]     slv_addr_o,
  output logic [DW-1:0]      slv_wdata_o
);

  logic [IW-1:0] sidx_s;
  logic          sel_ok_s;
  logic          err_s;
  logic [DW-1:0] rmux_s;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          err_q;

  assign sidx_s      = cfg_addr_i[AW-1:SAW];
  assign sel_ok_s    = (int'(sidx_s) < NSLV);
  assign slv_addr_o  = cfg_addr_i[SAW-1+REG_LSB:REG_LSB];
  assign slv_wdata_o = cfg_wdata_i;

  // A simultaneous read wins over the write; writes are only legal while idle.
  assign err_s = (cfg_r_i & ~sel_ok_s) |
                 (cfg_w_i & (cfg_r_i | ~idle_i | ~sel_ok_s));

  always_comb begin
    rmux_s   = '0;
    slv_we_o = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sidx_s == IW'(k)) begin
        rmux_s      = slv_rdata_i[k*DW +: DW];
        slv_we_o[k] = cfg_w_i & ~cfg_r_i & idle_i;
      end else begin
        slv_we_o[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (cfg_r_i) begin
        rdata_q <= rmux_s;
      end
      rvalid_q <= cfg_r_i;
      err_q    <= err_s;
    end
  end

  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;

endmodule

// File: rtl/ctrlseq.sv
// Measurement sequencer: arms the sampler once per run, collects detector
// results, counts hits, enforces a per-run timeout and fronts the slave banks.
module ctrlseq
  import sync_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NSLV = DEF_NSLV,
  parameter int SAW  = DEF_SAW,
  parameter int RW   = DEF_RW,
  parameter int TW   = DEF_TW,
  localparam int AW  = addr_w(NSLV, SAW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [RW-1:0]      run_cnt_i,
  input  logic [TW-1:0]      timeout_i,
  input  logic               cfg_w_i,
  input  logic               cfg_r_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [DW-1:0]      cfg_wdata_i,
  output logic [DW-1:0]      cfg_rdata_o,
  output logic               cfg_rvalid_o,
  output logic               cfg_err_o,
  input  logic [NSLV*DW-1:0] slv_rdata_i,
  output logic [NSLV-1:0]    slv_we_o,
  output logic [SAW-1:0]     slv_addr_o,
  output logic [DW-1:0]      slv_wdata_o,
  output logic               sampler_start_o,
  input  logic               det_finish_i,
  input  logic               det_data_i,
  output logic               res_valid_o,
  output logic               res_data_o,
  output logic [RW-1:0]      res_idx_o,
  output logic [RW-1:0]      hit_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               to_err_o
);

  state_e        state_q, state_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [RW-1:0] run_idx_q, run_idx_d;
  logic [RW-1:0] res_idx_q, res_idx_d;
  logic [RW-1:0] hit_cnt_q, hit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_err_q, to_err_d;
  logic          res_valid_q, res_valid_d;
  logic          res_data_q, res_data_d;
  logic          last_run_s;
  logic          expire_s;

  // run_cnt of zero means free-running, so the wrap of run_idx+1 to zero must not end it.
  assign last_run_s = (run_cnt_q != '0) && ((run_idx_q + RW'(1)) == run_cnt_q);
  assign expire_s   = (tmo_q != '0) && (tmr_q == TW'(1));

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    run_idx_d   = run_idx_q;
    res_idx_d   = res_idx_q;
    hit_cnt_d   = hit_cnt_q;
    tmo_d       = tmo_q;
    tmr_d       = tmr_q;
    to_err_d    = to_err_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_ARM;
          run_cnt_d  = run_cnt_i;
          tmo_d      = timeout_i;
          run_idx_d  = '0;
          res_idx_d  = '0;
          hit_cnt_d  = '0;
          to_err_d   = 1'b0;
          res_data_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MEAS;
          tmr_d   = tmo_q;
        end
      end
      ST_MEAS: begin
        // Priority: abort, then detector result, then timeout.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (det_finish_i) begin
          res_valid_d = 1'b1;
          res_data_d  = det_data_i;
          res_idx_d   = run_idx_q;
          if (det_data_i && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + RW'(1);
          end else begin
            hit_cnt_d = hit_cnt_q;
          end
          if (last_run_s) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_ARM;
            run_idx_d = run_idx_q + RW'(1);
          end
        end else if (expire_s) begin
          to_err_d = 1'b1;
          state_d  = ST_DONE;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          tmr_d = tmr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_cnt_q   <= '0;
      run_idx_q   <= '0;
      res_idx_q   <= '0;
      hit_cnt_q   <= '0;
      tmo_q       <= '0;
      tmr_q       <= '0;
      to_err_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      run_idx_q   <= run_idx_d;
      res_idx_q   <= res_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      tmo_q       <= tmo_d;
      tmr_q       <= tmr_d;
      to_err_q    <= to_err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign sampler_start_o = (state_q == ST_ARM);
  assign done_o          = (state_q == ST_DONE);
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_idx_o       = res_idx_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign to_err_o        = to_err_q;

  ctrlseq_cfgmux #(
    .DW   (DW),
    .NSLV (NSLV),
    .SAW  (SAW)
  ) u_cfgmux (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_w_i      (cfg_w_i),
    .cfg_r_i      (cfg_r_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .idle_i       (state_q == ST_IDLE),
    .slv_rdata_i  (slv_rdata_i),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_err_o    (cfg_err_o),
    .slv_we_o     (slv_we_o),
    .slv_addr_o   (slv_addr_o),
    .slv_wdata_o  (slv_wdata_o)
  );

endmodule

// File: tb/tb_ctrlseq.sv
// Scoreboard bench for ctrlseq: stimulus pushes expected results/reads, a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_ctrlseq;

  localparam int DW = 16, NSLV = 4, SAW = 2, RW = 8, TW = 16, AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_i, abort_i, cfg_w_i, cfg_r_i, det_finish_i, det_data_i;
  logic [RW-1:0] run_cnt_i;
  logic [TW-1:0] timeout_i;
  logic [AW-1:0] cfg_addr_i;
  logic [DW-1:0] cfg_wdata_i, cfg_rdata_o, slv_wdata_o;
  logic [NSLV*DW-1:0] slv_rdata_i;
  logic [NSLV-1:0] slv_we_o;
  logic [SAW-1:0] slv_addr_o;
  logic cfg_rvalid_o, cfg_err_o, sampler_start_o, res_valid_o, res_data_o;
  logic busy_o, done_o, to_err_o;
  logic [RW-1:0] res_idx_o, hit_cnt_o;

  // second instance with a non-power-of-two slave count
  logic c3_w, c3_r, c3_rvalid, c3_err, c3_samp, c3_rv, c3_rd, c3_busy, c3_done, c3_toerr;
  logic [AW-1:0] c3_addr;
  logic [DW-1:0] c3_rdata, c3_wdata;
  logic [3*DW-1:0] c3_slv_rdata;
  logic [2:0] c3_we;
  logic [SAW-1:0] c3_saddr;
  logic [RW-1:0] c3_idx, c3_hit;

  assign slv_rdata_i  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
  assign c3_slv_rdata = {16'hC2C2, 16'hB1B1, 16'hA0A0};

  ctrlseq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .run_cnt_i(run_cnt_i), .timeout_i(timeout_i), .cfg_w_i(cfg_w_i), .cfg_r_i(cfg_r_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_err_o(cfg_err_o), .slv_rdata_i(slv_rdata_i),
    .slv_we_o(slv_we_o), .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
    .sampler_start_o(sampler_start_o), .det_finish_i(det_finish_i), .det_data_i(det_data_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_idx_o(res_idx_o),
    .hit_cnt_o(hit_cnt_o), .busy_o(busy_o), .done_o(done_o), .to_err_o(to_err_o)
  );

  ctrlseq #(.NSLV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(1'b0), .abort_i(1'b0),
    .run_cnt_i(8'd0), .timeout_i(16'd0), .cfg_w_i(c3_w), .cfg_r_i(c3_r),
    .cfg_addr_i(c3_addr), .cfg_wdata_i(c3_wdata), .cfg_rdata_o(c3_rdata),
    .cfg_rvalid_o(c3_rvalid), .cfg_err_o(c3_err), .slv_rdata_i(c3_slv_rdata),
    .slv_we_o(c3_we), .slv_addr_o(c3_saddr), .slv_wdata_o(),
    .sampler_start_o(c3_samp), .det_finish_i(1'b0), .det_data_i(1'b0),
    .res_valid_o(c3_rv), .res_data_o(c3_rd), .res_idx_o(c3_idx),
    .hit_cnt_o(c3_hit), .busy_o(c3_busy), .done_o(c3_done), .to_err_o(c3_toerr)
  );

  typedef struct packed { logic d; logic [RW-1:0] idx; } res_t;
  typedef struct packed { logic [DW-1:0] d; logic e; } rd_t;
  res_t res_q[$];
  rd_t  rd_q[$];
  rd_t  rd3_q[$];
  int total = 0, bad = 0, n_res = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    res_t er;
    rd_t  ed;
    if (rst_n) begin
      if (res_valid_o) begin
        n_res++;
        total++;
        if (res_q.size() == 0) begin
          bad++;
          $display("FAIL res_unexpected: got idx %0d want no result", res_idx_o);
        end else begin
          er = res_q.pop_front();
          chk("res_data", {31'd0, res_data_o}, {31'd0, er.d});
          chk("res_idx", {24'd0, res_idx_o}, {24'd0, er.idx});
        end
      end
      if (done_o) n_done++;
      if (cfg_rvalid_o) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got %0h want no read", cfg_rdata_o);
        end else begin
          ed = rd_q.pop_front();
          chk("rdata", {16'd0, cfg_rdata_o}, {16'd0, ed.d});
          chk("rd_err", {31'd0, cfg_err_o}, {31'd0, ed.e});
        end
      end
      if (c3_rvalid) begin
        total++;
        if (rd3_q.size() == 0) begin
          bad++;
          $display("FAIL rd3_unexpected: got %0h want no read", c3_rdata);
        end else begin
          ed = rd3_q.pop_front();
          chk("rdata3", {16'd0, c3_rdata}, {16'd0, ed.d});
          chk("rd3_err", {31'd0, c3_err}, {31'd0, ed.e});
        end
      end
    end
  end

  task automatic go(input logic [RW-1:0] rc, input logic [TW-1:0] to);
    tick();
    start_i = 1'b1; run_cnt_i = rc; timeout_i = to;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_samp(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!sampler_start_o && n < 100);
    chk(name, {31'd0, sampler_start_o}, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done_o && cyc < 100);
    chk("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, r0, d0;
    logic [2:0] pat;
    start_i = 1'b0; abort_i = 1'b0; cfg_w_i = 1'b0; cfg_r_i = 1'b0;
    det_finish_i = 1'b0; det_data_i = 1'b0; run_cnt_i = '0; timeout_i = '0;
    cfg_addr_i = '0; cfg_wdata_i = '0;
    c3_w = 1'b0; c3_r = 1'b0; c3_addr = '0; c3_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", {busy_o, done_o, to_err_o, res_valid_o, sampler_start_o, cfg_rvalid_o, cfg_err_o},
        32'd0);
    chk("rst_cnt", {hit_cnt_o, res_idx_o}, 32'd0);

    // Three runs, hits 1,0,1
    pat = 3'b101;
    go(8'd3, 16'd0);
    for (int i = 0; i < 3; i++) begin
      wait_samp("t3_samp");
      @(negedge clk);
      chk("samp_one_cycle", {31'd0, sampler_start_o}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      det_finish_i = 1'b1; det_data_i = pat[i];
      res_q.push_back('{pat[i], RW'(i)});
      tick();
      det_finish_i = 1'b0;
    end
    wait_done(cyc);
    @(negedge clk);
    chk("t3_hit", {24'd0, hit_cnt_o}, 32'd2);
    chk("t3_idx", {24'd0, res_idx_o}, 32'd2);
    chk("t3_nres", n_res, 3);
    chk("t3_ndone", n_done, 1);
    chk("t3_idle", {31'd0, busy_o}, 32'd0);

    // Timeout of 10 cycles, no detector
    r0 = n_res;
    go(8'd1, 16'd10);
    wait_samp("tmo_samp");
    wait_done(cyc);
    chk("tmo_latency", cyc, 11);
    chk("tmo_err", {31'd0, to_err_o}, 32'd1);
    @(negedge clk);
    chk("tmo_nres", n_res, r0);

    // Reset mid-sequence
    d0 = n_done;
    go(8'd2, 16'd0);
    wait_samp("rst_samp");
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    tick(); rst_n = 1'b1;

    // det_finish together with abort
    go(8'd2, 16'd0);
    wait_samp("ab_samp");
    tick();
    det_finish_i = 1'b1; det_data_i = 1'b1; abort_i = 1'b1;
    tick();
    det_finish_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    chk("ab_idle", {31'd0, busy_o}, 32'd0);
    chk("ab_nres", n_res, r0);
    chk("ab_ndone", n_done, d0);

    // det_finish together with timeout expiry
    go(8'd1, 16'd3);
    wait_samp("race_samp");
    repeat (3) @(posedge clk);
    #1;
    det_finish_i = 1'b1; det_data_i = 1'b1;
    res_q.push_back('{1'b1, 8'd0});
    tick();
    det_finish_i = 1'b0;
    wait_done(cyc);
    @(negedge clk);
    chk("race_toerr", {31'd0, to_err_o}, 32'd0);
    chk("race_hit", {24'd0, hit_cnt_o}, 32'd1);

    // Continuous mode: 300 runs, index wrap, hit saturation, then abort
    d0 = n_done;
    go(8'd0, 16'd0);
    for (int i = 0; i < 300; i++) begin
      wait_samp("cont_samp");
      tick();
      det_finish_i = 1'b1; det_data_i = 1'b1;
      res_q.push_back('{1'b1, RW'(i)});
      tick();
      det_finish_i = 1'b0;
    end
    @(negedge clk);
    chk("cont_idx", {24'd0, res_idx_o}, 32'd43);
    chk("cont_hit_sat", {24'd0, hit_cnt_o}, 32'd255);
    tick();
    abort_i = 1'b1;
    @(negedge clk);
    chk("cont_busy", {31'd0, busy_o}, 32'd1);
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    chk("cont_abort_idle", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("cont_ndone", n_done, d0);

    // Writes while busy are rejected; reads still serviced
    go(8'd1, 16'd0);
    cfg_w_i = 1'b1; cfg_addr_i = 4'b0110; cfg_wdata_i = 16'h5A5A;
    @(negedge clk);
    chk("wbusy_we", {28'd0, slv_we_o}, 32'd0);
    tick();
    cfg_w_i = 1'b0; cfg_r_i = 1'b1; cfg_addr_i = 4'b0000;
    rd_q.push_back('{16'hA0A0, 1'b0});
    @(negedge clk);
    chk("wbusy_err", {31'd0, cfg_err_o}, 32'd1);
    tick();
    cfg_r_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    chk("w_idle", {31'd0, busy_o}, 32'd0);

    // Same write while idle
    tick();
    cfg_w_i = 1'b1; cfg_addr_i = 4'b0110;
    @(negedge clk);
    chk("widle_we", {28'd0, slv_we_o}, 32'h2);
    chk("widle_addr", {30'd0, slv_addr_o}, 32'd2);
    chk("widle_wdata", {16'd0, slv_wdata_o}, 32'h5A5A);
    tick();
    cfg_w_i = 1'b0;
    @(negedge clk);
    chk("widle_err", {31'd0, cfg_err_o}, 32'd0);

    // Read and write together: read wins, write dropped, error flagged
    tick();
    cfg_w_i = 1'b1; cfg_r_i = 1'b1; cfg_addr_i = 4'b0110;
    rd_q.push_back('{16'hB1B1, 1'b1});
    @(negedge clk);
    chk("rw_we", {28'd0, slv_we_o}, 32'd0);
    tick();
    cfg_w_i = 1'b0;
    cfg_addr_i = 4'b1100;
    rd_q.push_back('{16'hD3D3, 1'b0});
    tick();
    cfg_addr_i = 4'b1001;
    rd_q.push_back('{16'hC2C2, 1'b0});
    tick();
    cfg_r_i = 1'b0;

    // Three-slave instance: out-of-range slave index
    c3_r = 1'b1; c3_addr = 4'b1100;
    rd3_q.push_back('{16'h0000, 1'b1});
    tick();
    c3_addr = 4'b0100;
    rd3_q.push_back('{16'hB1B1, 1'b0});
    tick();
    c3_r = 1'b0; c3_w = 1'b1; c3_addr = 4'b1110; c3_wdata = 16'h1234;
    @(negedge clk);
    chk("w3_bad_we", {29'd0, c3_we}, 32'd0);
    tick();
    c3_addr = 4'b0110;
    @(negedge clk);
    chk("w3_bad_err", {31'd0, c3_err}, 32'd1);
    chk("w3_we", {29'd0, c3_we}, 32'h2);
    chk("w3_addr", {30'd0, c3_saddr}, 32'd2);
    tick();
    c3_w = 1'b0;

    repeat (4) @(negedge clk);
    chk("res_q_left", res_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    chk("rd3_q_left", rd3_q.size(), 0);
    chk("total_res", n_res, 304);
    chk("total_done", n_done, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
